// File: rtl/fft_feed_pkg.sv
// fft_feed_pkg: shared framing state type and sample alignment helper.
package fft_feed_pkg;

    typedef enum logic {STREAM, FLUSH} feed_state_t;

    function automatic int align_shift(input int sample_w, input int data_w);
        return data_w - sample_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head word; the caller guards full/empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_count;

    always_ff @(posedge clk_in)
        if (wr_en) r_mem[r_wp] <= wr_data;

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + AW'(wr_en);
            r_rp    <= r_rp + AW'(rd_en);
            r_count <= r_count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end

    assign rd_data = r_mem[r_rp];
    assign count   = r_count;

endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers audio samples and streams them as FFT_LEN-sized AXI-Stream frames,
// zero-padding the current frame on flush.
module fft_frame_feeder
    import fft_feed_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [SAMPLE_W-1:0]         sample_in,
    input  logic                        sample_valid_in,
    input  logic                        flush_in,
    output logic [2*DATA_W-1:0]         m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0] fill_out,
    output logic [31:0]                 frame_count_out,
    output logic                        overflow_out,
    output logic [15:0]                 drop_count_out
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int IW    = $clog2(FRAME_LEN);
    localparam int SHIFT = align_shift(SAMPLE_W, DATA_W);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    feed_state_t         r_state;
    logic [IW-1:0]       r_idx, w_idx_nxt;
    logic [CW-1:0]       r_drain, w_drain_nxt, w_count;
    logic [SAMPLE_W-1:0] w_head;
    logic [DATA_W-1:0]   w_real;
    logic [2*DATA_W-1:0] r_tdata;
    logic                r_tvalid, r_tlast, r_src, r_ovf;
    logic [31:0]         r_frames;
    logic [15:0]         r_drops;
    logic                w_wr, w_hs, w_rd, w_wrap, w_go_flush, w_done, w_from_fifo, w_load;

    // The presented word stays at the FIFO head until its handshake, so fill counts it.
    sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (w_wr),
        .wr_data (sample_in),
        .rd_en   (w_rd),
        .rd_data (w_head),
        .count   (w_count)
    );

    assign w_real      = DATA_W'($signed(w_head)) << SHIFT;
    assign w_wr        = sample_valid_in && (w_count != FULL);
    assign w_hs        = r_tvalid && m_axis_tready;
    assign w_rd        = w_hs && r_src;
    assign w_idx_nxt   = r_idx + IW'(w_hs);
    assign w_wrap      = w_hs && (r_idx == LAST);
    assign w_drain_nxt = r_drain - CW'(w_rd && r_state == FLUSH);
    assign w_go_flush  = (r_state == STREAM) && flush_in && ((w_idx_nxt != '0) || (w_count != CW'(w_rd)));
    // Leave FLUSH only on a frame end once every word buffered at flush time has gone out.
    assign w_done      = (r_state == FLUSH) && w_wrap && (w_drain_nxt == '0);
    assign w_from_fifo = (r_state == STREAM) ? (w_count != '0) : (r_drain != '0);
    assign w_load      = !r_tvalid && (w_from_fifo || r_state == FLUSH);

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            r_state  <= STREAM;
            r_idx    <= '0;
            r_drain  <= '0;
            r_src    <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_frames <= '0;
            r_ovf    <= 1'b0;
            r_drops  <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_drain <= w_go_flush ? w_count - CW'(w_rd) : w_drain_nxt;
            r_state <= w_go_flush ? FLUSH : (w_done ? STREAM : r_state);
            if (w_wrap) r_frames <= r_frames + 32'd1;
            if (sample_valid_in && !w_wr) begin
                r_ovf   <= 1'b1;
                r_drops <= r_drops + 16'(r_drops != 16'hFFFF);
            end
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_src    <= w_from_fifo;
                r_tlast  <= (r_idx == LAST);
                r_tdata  <= w_from_fifo ? {{DATA_W{1'b0}}, w_real} : '0;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end

    assign m_axis_tdata    = r_tdata;
    assign m_axis_tvalid   = r_tvalid;
    assign m_axis_tlast    = r_tlast;
    assign fill_out        = w_count;
    assign frame_count_out = r_frames;
    assign overflow_out    = r_ovf;
    assign drop_count_out  = r_drops;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: randomized and directed checks against a word-stream reference model.
module tb_fft_frame_feeder;
    localparam int SW    = 12;
    localparam int DW    = 16;
    localparam int FL    = 8;
    localparam int DEPTH = 32;
    localparam int PAD   = 'h10000;

    logic                     clk_in = 1'b0;
    logic                     rst_in = 1'b1;
    logic [SW-1:0]            sample_in = '0;
    logic                     sample_valid_in = 1'b0;
    logic                     flush_in = 1'b0;
    logic                     m_axis_tready = 1'b0;
    logic [2*DW-1:0]          m_axis_tdata;
    logic                     m_axis_tvalid, m_axis_tlast;
    logic [$clog2(DEPTH):0]   fill_out;
    logic [31:0]              frame_count_out;
    logic                     overflow_out;
    logic [15:0]              drop_count_out;

    always #5 clk_in = ~clk_in;

    fft_frame_feeder #(.SAMPLE_W(SW), .DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .flush_in        (flush_in),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .fill_out        (fill_out),
        .frame_count_out (frame_count_out),
        .overflow_out    (overflow_out),
        .drop_count_out  (drop_count_out)
    );

    int total = 0, bad = 0;
    // Expected word stream: data words are MSB-aligned samples, PAD marks a zero pad word.
    int q[$];
    int n_data = 0, p_len = 0, h = 0, gate = 0, m_drops = 0;
    logic m_ovf = 1'b0, prev_stall = 1'b0, prev_last = 1'b0, any_valid = 1'b0;
    logic [2*DW-1:0] prev_data = '0, last_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        n_data = 0; p_len = 0; h = 0; gate = 0; m_drops = 0;
        m_ovf = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic step(input logic v, input logic [SW-1:0] s, input logic fl, input logic rdy);
        int w;
        @(negedge clk_in);
        chk("fill", fill_out, n_data);
        chk("drops", drop_count_out, m_drops);
        chk("ovf", overflow_out, m_ovf);
        chk("frames", frame_count_out, h / FL);
        if (prev_stall) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_data", m_axis_tdata, prev_data);
            chk("hold_last", m_axis_tlast, prev_last);
        end
        any_valid |= m_axis_tvalid;
        sample_valid_in = v; sample_in = s; flush_in = fl; m_axis_tready = rdy;
        if (v && !rst_in) begin
            if (n_data < DEPTH) begin
                q.push_back((int'(s) << (DW - SW)) & 'hFFFF);
                n_data++; p_len++;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 'hFFFF) m_drops++;
            end
        end
        if (fl && !rst_in && gate == 0) begin
            while (p_len % FL != 0) begin
                q.push_back(PAD);
                p_len++;
            end
            gate = q.size();
        end
        if (m_axis_tvalid && rdy) begin
            if (q.size() == 0) chk("hs_unexpected", m_axis_tvalid, 0);
            else begin
                w = q.pop_front();
                chk("tdata", m_axis_tdata, (w == PAD) ? 0 : w);
                chk("tlast", m_axis_tlast, (h % FL) == FL - 1);
                if (w != PAD) n_data--;
                h++;
                if (gate > 0) gate--;
                last_data = m_axis_tdata;
            end
        end
        prev_stall = m_axis_tvalid && !rdy;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(0, '0, 0, 1);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        step(0, '0, 0, 1);
    endtask

    task automatic send_spaced(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            step(1, SW'(base + i), 0, 1);
            step(0, '0, 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_fill", fill_out, 0);
        chk("rst_frames", frame_count_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_drops", drop_count_out, 0);
        rst_in = 1'b0;

        send_spaced(16, 1);
        drain(200);
        chk("two_frames", frame_count_out, 2);

        send_spaced(3, 'h10);
        step(0, '0, 1, 1);
        drain(200);
        chk("flush_frames", frame_count_out, 3);
        any_valid = 1'b0;
        step(0, '0, 1, 1);
        repeat (20) step(0, '0, 0, 1);
        chk("noop_flush", any_valid, 0);

        step(1, 12'h800, 0, 1);
        drain(50);
        chk("align_neg", last_data, 32'h0000_8000);
        step(1, 12'h001, 0, 1);
        drain(50);
        chk("align_pos", last_data, 32'h0000_0010);

        for (int i = 0; i < DEPTH + 2; i++) step(1, SW'(i * 37 + 5), 0, 0);
        step(0, '0, 0, 0);
        chk("full_fill", fill_out, DEPTH);
        chk("full_drops", drop_count_out, 2);
        chk("full_ovf", overflow_out, 1);
        drain(300);

        begin
            int sent = 0, gap = 0;
            while (sent < 1000) begin
                gap++;
                if (gap >= 3 && $urandom_range(1, 0) == 1) begin
                    step(1, SW'($urandom), 0, $urandom_range(3, 0) != 0);
                    sent++;
                    gap = 0;
                end else
                    step(0, '0, $urandom_range(99, 0) == 0, $urandom_range(3, 0) != 0);
            end
        end
        drain(3000);
        chk("rand_no_loss", drop_count_out, 2);

        if (h % FL != 0) begin
            step(0, '0, 1, 1);
            drain(200);
        end
        send_spaced(5, 'h40);
        drain(100);
        step(1, 12'h5A5, 0, 0);
        repeat (3) step(0, '0, 0, 0);
        chk("pre_rst_valid", m_axis_tvalid, 1);
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        model_reset();
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_tlast", m_axis_tlast, 0);
        chk("arst_tdata", m_axis_tdata, 0);
        chk("arst_fill", fill_out, 0);
        chk("arst_frames", frame_count_out, 0);
        chk("arst_ovf", overflow_out, 0);
        chk("arst_drops", drop_count_out, 0);
        step(1, 12'h3C3, 0, 1);
        step(1, 12'h3C4, 0, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        sample_valid_in = 1'b0;
        send_spaced(8, 'h70);
        drain(100);
        chk("post_rst_frames", frame_count_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 Parameters SHALL be: SAMPLE_W, default 16, input sample width (signed, 8..24); DATA_W, default 16, real/imag field width (DATA_W >= SAMPLE_W); FRAME_LEN, default 1024, samples per FFT frame (power of 2, 8..65536); FIFO_DEPTH, default 64, buffer entries (power of 2, >= 4).
REQ-002 clk_in  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 rst_in  input  1  reset; asynchronous and active-high.
REQ-004 sample_in  input  SAMPLE_W  signed audio sample.
REQ-005 sample_valid_in  input  1  single-cycle strobe; sample_in is valid this cycle; the block has no backpressure to this input.
REQ-006 flush_in  input  1  pulse; zero-pads the current frame to completion.
REQ-007 m_axis_tdata  output  2*DATA_W  FFT input word: [DATA_W-1:0] real, [2*DATA_W-1:DATA_W] imag.
REQ-008 m_axis_tvalid / m_axis_tlast  output  1 each  AXI-Stream valid / last-of-frame.
REQ-009 m_axis_tready  input  1  AXI-Stream ready from the FFT core.
REQ-010 fill_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 frame_count_out  output  32  frames completed (tlast handshakes), wrapping.
REQ-012 overflow_out  output  1  sticky flag: at least one sample was dropped.
REQ-013 drop_count_out  output  16  dropped samples, saturating at 16'hFFFF.

Function
REQ-014 Real field SHALL be sample_in sign-extended and left-shifted by DATA_W-SAMPLE_W (MSB-aligned); imag field SHALL be 0.
REQ-015 A sample SHALL be written when sample_valid_in=1 and fill < FIFO_DEPTH, evaluated on the pre-edge fill; a same-cycle read SHALL NOT admit a write into a full FIFO.
REQ-016 A sample arriving while full SHALL be dropped: overflow_out set, drop_count_out incremented (saturating); frame alignment is unaffected.
REQ-017 A sample written into an empty FIFO at edge N SHALL present tvalid=1 after edge N+1; the output is registered.
REQ-018 tdata/tvalid/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-019 The output index counter (0..FRAME_LEN-1) SHALL advance only on a tvalid&&tready handshake; tlast=1 exactly when index==FRAME_LEN-1; it wraps to 0 and frame_count_out increments on that handshake.
REQ-020 FSM states: STREAM and FLUSH. STREAM->FLUSH on flush_in=1 when index!=0 or fill!=0; flush_in with index==0 and fill==0 is a no-op.
REQ-021 In FLUSH the FIFO SHALL drain first, then zero words (tdata=0) SHALL be emitted until the tlast handshake; then return to STREAM.
REQ-022 In FLUSH, incoming samples SHALL still be written per REQ-015 but SHALL NOT be read until return to STREAM; flush_in during FLUSH is ignored.
REQ-023 If the FIFO refills during padding, padding SHALL still complete the frame; buffered samples begin the next frame.
REQ-024 fill_out SHALL reflect post-edge occupancy, including simultaneous read and write (unchanged).

Reset
REQ-025 While rst_in=1: tvalid=0, tlast=0, tdata=0, fill_out=0, index=0, frame_count_out=0, overflow_out=0, drop_count_out=0, state=STREAM; FIFO contents discarded.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without a tlast; the first post-reset sample is index 0.
REQ-027 Samples presented while rst_in=1 SHALL be ignored.

Structure
REQ-028 Package fft_feed_pkg SHALL hold the state enum (STREAM, FLUSH) and the helper function computing the alignment shift.
REQ-029 Buffering SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk_in, rst_in, wr_en, wr_data, rd_en, rd_data, count); the framing FSM and counters live in fft_frame_feeder.

Verification
REQ-030 FRAME_LEN=8, tready=1, samples 1..16 -> 16 words, real=i<<0 (SAMPLE_W=DATA_W=16), tlast on the 8th and 16th, frame_count_out=2.
REQ-031 SAMPLE_W=12, DATA_W=16, sample 12'h800 -> real=16'h8000, imag=0; sample 12'h001 -> real=16'h0010.
REQ-032 FIFO_DEPTH=4, tready=0, 6 samples -> fill_out=4, drop_count_out=2, overflow_out=1; with tready=1, first 4 samples emerge in order.
REQ-033 FRAME_LEN=8, 3 samples then flush_in -> 3 data words, 5 zero words, tlast on the 8th, state returns to STREAM; flush_in at index 0 with an empty FIFO -> no output.
REQ-034 Random tready toggling over 1000 samples -> no data change while stalled, no loss when the source rate is below 1 per 2 cycles, tlast every FRAME_LEN handshakes.
REQ-035 rst_in asserted at index 5 -> all outputs are zero immediately (asynchronous reset); the next frame starts at index 0 with no tlast for the abandoned frame.
